// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder for a simple CPU load/store port.
// One request at a time: accept in IDLE, count down LATENCY cycles in WAIT,
// perform the access on the edge entering RESP, pulse ack for one cycle.
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_next_s;
  logic              we_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic              accept_s;
  logic              access_s;
  logic              op_we_s;
  logic [31:0]       op_addr_s;
  logic [31:0]       op_wdata_s;
  logic              op_err_s;
  logic [IDX_W-1:0]  op_idx_s;
  logic [31:0]       rdata_next_s;
  logic [31:0]       mem_r [DEPTH];
  logic              busy_r;
  logic              ack_r;
  logic              err_r;
  logic [31:0]       rdata_r;

  // Misaligned or beyond-the-end addresses never touch storage.
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
  endfunction

  // Operand select: in IDLE the live inputs are used so a zero-latency
  // request can access storage on its acceptance edge.
  always_comb begin
    op_we_s    = we_r;
    op_addr_s  = addr_r;
    op_wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      op_we_s    = we_i;
      op_addr_s  = addr_i;
      op_wdata_s = wdata_i;
    end else begin
      op_we_s    = we_r;
      op_addr_s  = addr_r;
      op_wdata_s = wdata_r;
    end
  end

  assign op_idx_s = op_addr_s[IDX_W+1:2];
  assign op_err_s = addr_bad(op_addr_s);

  // Next-state and wait-counter logic; access_s marks the edge entering RESP.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    access_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_i) begin
          accept_s = 1'b1;
          if (LATENCY == 0) begin
            state_next_s = ST_RESP;
            cnt_next_s   = 4'd0;
            access_s     = 1'b1;
          end else begin
            state_next_s = ST_WAIT;
            cnt_next_s   = 4'(LATENCY);
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_next_s = ST_RESP;
          access_s     = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Load data is only returned for a successful load; stores and errors give 0.
  always_comb begin
    rdata_next_s = 32'h0000_0000;
    if (access_s && !op_we_s && !op_err_s) begin
      rdata_next_s = mem_r[op_idx_s];
    end else begin
      rdata_next_s = 32'h0000_0000;
    end
  end

  // State, counter and latched request fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        we_r    <= we_i;
        addr_r  <= addr_i;
        wdata_r <= wdata_i;
      end
    end
  end

  // Registered response outputs, all zero outside the RESP cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      busy_r  <= (state_next_s != ST_IDLE);
      ack_r   <= access_s;
      err_r   <= access_s & op_err_s;
      rdata_r <= rdata_next_s;
    end
  end

  // Word storage: cleared by reset, written whole-word on a good store.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (access_s && op_we_s && !op_err_s) begin
      mem_r[op_idx_s] <= op_wdata_s;
    end
  end

  assign busy_o  = busy_r;
  assign ack_o   = ack_r;
  assign err_o   = err_r;
  assign rdata_o = rdata_r;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
- REQ-001: Parameter DEPTH, default 128, number of 32-bit words of storage.
- REQ-002: Parameter LATENCY, default 2, wait cycles between request acceptance and response (legal range 0..15).
- REQ-003: clk_i  input  1  single clock; all state updates on rising edge.
- REQ-004: rst_i  input  1  reset, synchronous, active-high.
- REQ-005: req_i  input  1  CPU request strobe, sampled only while idle.
- REQ-006: we_i  input  1  1 = store word, 0 = load word; sampled with req_i.
- REQ-007: addr_i  input  32  byte address; word index = addr_i[31:2].
- REQ-008: wdata_i  input  32  store data; sampled with req_i.
- REQ-009: busy_o  output  1  high while a request is in flight (WAIT or RESP).
- REQ-010: ack_o  output  1  one-cycle response pulse.
- REQ-011: rdata_o  output  32  load data, valid only while ack_o=1.
- REQ-012: err_o  output  1  error flag, valid only while ack_o=1.

Function
- REQ-013: The block SHALL implement three states: IDLE, WAIT, RESP.
- REQ-014: IDLE with req_i=1 at a rising edge SHALL latch we_i, addr_i, and wdata_i, load the wait counter with LATENCY, and go to WAIT (LATENCY>0) or RESP (LATENCY=0).
- REQ-015: IDLE with req_i=0 SHALL stay in IDLE.
- REQ-016: WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 1.
- REQ-017: Latency: a request accepted at edge k SHALL produce ack_o=1 during cycle k+1+LATENCY only.
- REQ-018: The memory read or write SHALL be performed on the edge that enters RESP.
  - For stores, storage SHALL change at that edge.
  - For loads, rdata_o SHALL present the word stored at that edge.
- REQ-019: RESP SHALL last exactly one cycle with ack_o=1, then return to IDLE unconditionally.
- REQ-020: busy_o SHALL be 1 in WAIT and RESP, and 0 in IDLE.
- REQ-021: req_i asserted in WAIT or RESP SHALL be ignored: it is not queued and there is no error.
  - The earliest next acceptance is the cycle after RESP.
  - Minimum request spacing is therefore LATENCY+2 cycles.
- REQ-022: A misaligned address (addr[1:0]!=0) SHALL cause no storage access and an ack with err_o=1, rdata_o=0, after the normal latency.
- REQ-023: An out-of-range address (addr[31:2] >= DEPTH) SHALL behave as in REQ-022.
- REQ-024: A successful store SHALL ack with err_o=0 and rdata_o=0.
- REQ-025: Outside the RESP cycle, ack_o, err_o, and rdata_o SHALL all be 0.
- REQ-026: Latched request fields SHALL be unaffected by input changes after acceptance.
- REQ-027: Storage SHALL be word-granular only: no byte or halfword enables, and no read-modify-write.

Reset
- REQ-028: While rst_i=1 at a rising edge, the block SHALL enter IDLE, clear the wait counter, and drive busy_o, ack_o, err_o, and rdata_o to 0 in the following cycle.
- REQ-029: Reset SHALL clear every storage word to 0x00000000.
- REQ-030: Reset asserted in WAIT SHALL abort the request: a pending store is not committed and no ack is issued.
- REQ-031: Reset asserted in RESP SHALL suppress any further ack.
  - The store committed on the preceding edge is then overwritten by the storage clear.
- REQ-032: req_i asserted together with rst_i SHALL be ignored.

Verification
- REQ-033: LATENCY=2: store 0x12345678 to addr 0x10, then load 0x10.
  - Store ack SHALL occur 3 cycles after its req, with err_o=0.
  - Load ack SHALL occur 3 cycles after its req, with rdata_o=0x12345678.
- REQ-034: LATENCY=0: load addr 0x0 after reset. The ack SHALL occur in the next cycle with rdata_o=0x00000000 and err_o=0.
- REQ-035: Store to addr 0x13 (misaligned), then load 0x10. The first ack SHALL have err_o=1, and word 4 SHALL remain unchanged.
- REQ-036: DEPTH=128: load addr 0x200. The ack SHALL have err_o=1 and rdata_o=0.
- REQ-037: LATENCY=2: a req pulse one cycle after acceptance SHALL be ignored, giving exactly one ack and busy_o high for 3 cycles.
- REQ-038: A store of 0xDEADBEEF to addr 0x8 with rst_i pulsed during WAIT SHALL produce no ack, and a subsequent load of 0x8 SHALL return 0x00000000.
